// File: rtl/mdr_pkg.sv
// Shared types and constants for the MAR/MDR memory port.
// Parity support is enabled by defining MDR_PARITY_EN.
package mdr_pkg;

  localparam int WAIT_CNT_W = 4;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int WAIT_DEF   = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR_WAIT,
    WR_END
  } mdr_state_t;

endpackage

// File: rtl/mdr_mem_port_if.sv
// SRAM-style memory bus between the port (master) and memory (slave).
// MDR_PARITY_EN adds the read parity input and write parity output.
interface mdr_mem_port_if
  import mdr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;
`ifdef MDR_PARITY_EN
  logic              mem_rpar;
  logic              mem_wpar;

  modport master (
    output mem_addr, mem_wdata,
    output mem_ce_n, mem_oe_n, mem_we_n,
    output mem_wpar,
    input  mem_rdata, mem_rpar
  );

  modport slave (
    input  mem_addr, mem_wdata,
    input  mem_ce_n, mem_oe_n, mem_we_n,
    input  mem_wpar,
    output mem_rdata, mem_rpar
  );
`else
  modport master (
    output mem_addr, mem_wdata,
    output mem_ce_n, mem_oe_n, mem_we_n,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata,
    input  mem_ce_n, mem_oe_n, mem_we_n,
    output mem_rdata
  );
`endif

endinterface

// File: rtl/mdr_mem_port_reg_n.sv
// Parametrised-width load register, synchronous active-low reset.
// Used for MAR and MDR (MDR widened by one when MDR_PARITY_EN is set).
module reg_n #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // hold unless loaded; reset clears
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/mdr_mem_port.sv
// MAR/MDR memory port: sequences SRAM reads and writes with wait states.
// Define MDR_PARITY_EN for read parity checking and write parity output.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              start_rd,
  input  logic              start_wr,
  mdr_mem_port_if.master    mem,
  output logic [ADDR_W-1:0] MAR_out,
  output logic [DATA_W-1:0] MDR_out,
  output logic              busy,
  output logic              done,
`ifdef MDR_PARITY_EN
  output logic              par_err,
`endif
  output logic              err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > (2**WAIT_CNT_W) - 1) begin : g_bad_wait
    $error("WAIT_CYCLES out of range 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

`ifdef MDR_PARITY_EN
  localparam int MDR_W = DATA_W + 1;
`else
  localparam int MDR_W = DATA_W;
`endif

  mdr_state_t            state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  err_nxt;
  logic                  ce_q, oe_q, we_q;
  logic                  busy_q, done_q, err_q;

  logic                  idle;
  logic                  mar_ld, mdr_ld;
  logic [ADDR_W-1:0]     mar_q;
  logic [DATA_W-1:0]     mdr_src;
  logic [MDR_W-1:0]      mdr_d, mdr_q;

  assign idle   = (state == IDLE);
  assign mar_ld = idle & LD_MAR;
  assign mdr_ld = (idle & LD_MDR) | (state == RD_CAP);
  assign mdr_src = ((state == RD_CAP) || MIO_EN) ? mem.mem_rdata : bus;

`ifdef MDR_PARITY_EN
  // stored bit is the even-parity bit of whatever data was loaded
  assign mdr_d        = {^mdr_src, mdr_src};
  assign mem.mem_wpar = mdr_q[DATA_W];
  assign par_err      = (state == RD_CAP) &
                        (^{mem.mem_rdata, mem.mem_rpar});
`else
  assign mdr_d = mdr_src;
`endif

  reg_n #(.W(ADDR_W)) u_mar (
    .clk   (Clk),
    .rst_n (Reset),
    .ld    (mar_ld),
    .d     (bus[ADDR_W-1:0]),
    .q     (mar_q)
  );

  reg_n #(.W(MDR_W)) u_mdr (
    .clk   (Clk),
    .rst_n (Reset),
    .ld    (mdr_ld),
    .d     (mdr_d),
    .q     (mdr_q)
  );

  // next state, wait counter and illegal-request detection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rd && start_wr) begin
          err_nxt = 1'b1;
        end else if (start_rd) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = WAIT_INIT;
        end else if (start_wr) begin
          state_nxt = WR_WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) state_nxt = RD_CAP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RD_CAP: state_nxt = IDLE;
      WR_WAIT: begin
        if (cnt == '0) state_nxt = WR_END;
        else           cnt_nxt   = cnt - 1'b1;
      end
      WR_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!idle && (start_rd || start_wr)) err_nxt = 1'b1;
  end

  // state and registered strobes/status decoded from the next state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ce_q   <= 1'b1;
      oe_q   <= 1'b1;
      we_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ce_q   <= (state_nxt == IDLE);
      oe_q   <= !(state_nxt == RD_WAIT || state_nxt == RD_CAP);
      we_q   <= !(state_nxt == WR_WAIT);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == RD_CAP || state_nxt == WR_END);
      err_q  <= err_nxt;
    end
  end

  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q[DATA_W-1:0];
  assign mem.mem_ce_n  = ce_q;
  assign mem.mem_oe_n  = oe_q;
  assign mem.mem_we_n  = we_q;
  assign MAR_out       = mar_q;
  assign MDR_out       = mdr_q[DATA_W-1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Randomised bench for mdr_mem_port against a transaction-age model.
// Define MDR_PARITY_EN to also exercise the parity ports.
module tb_mdr_mem_port;
  import mdr_pkg::*;

  localparam int W = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] bus = '0;
  logic        LD_MAR = 1'b0;
  logic        LD_MDR = 1'b0;
  logic        MIO_EN = 1'b0;
  logic        start_rd = 1'b0;
  logic        start_wr = 1'b0;
  logic [15:0] MAR_out, MDR_out;
  logic        busy, done, err;
`ifdef MDR_PARITY_EN
  logic        par_err;
  logic        rpar = 1'b0;
`endif

  logic [15:0] mem_img [256];

  int total = 0;
  int bad = 0;

  mdr_mem_port_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  assign mem_if.mem_rdata = mem_img[mem_if.mem_addr[7:0]];
`ifdef MDR_PARITY_EN
  assign mem_if.mem_rpar = rpar;
`endif

  mdr_mem_port #(
    .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .LD_MAR   (LD_MAR),
    .LD_MDR   (LD_MDR),
    .MIO_EN   (MIO_EN),
    .start_rd (start_rd),
    .start_wr (start_wr),
    .mem      (mem_if),
    .MAR_out  (MAR_out),
    .MDR_out  (MDR_out),
    .busy     (busy),
    .done     (done),
`ifdef MDR_PARITY_EN
    .par_err  (par_err),
`endif
    .err      (err)
  );

  always #5 Clk = ~Clk;

  // model: kind 0 none, 1 read, 2 write; age counts cycles since start
  logic [15:0] m_mar = '0;
  logic [15:0] m_mdr = '0;
  int          m_kind = 0;
  int          m_age = 0;
  logic        m_err = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] rd;
    rd = mem_img[m_mar[7:0]];
    if (!Reset) begin
      m_mar = '0; m_mdr = '0; m_kind = 0; m_age = 0; m_err = 1'b0;
    end else if (m_kind == 0) begin
      m_err = start_rd && start_wr;
      if (!m_err && start_rd) begin m_kind = 1; m_age = 1; end
      else if (!m_err && start_wr) begin m_kind = 2; m_age = 1; end
      if (LD_MAR) m_mar = bus;
      if (LD_MDR) m_mdr = MIO_EN ? rd : bus;
    end else begin
      m_err = start_rd || start_wr;
      if (m_age == W + 2) begin
        if (m_kind == 1) m_mdr = rd;
        m_kind = 0;
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_outs();
    logic busy_e, done_e;
    busy_e = (m_kind != 0);
    done_e = (m_age == W + 2);
    chk("busy", 32'(busy), 32'(busy_e));
    chk("done", 32'(done), 32'(done_e));
    chk("err", 32'(err), 32'(m_err));
    chk("ce_n", 32'(mem_if.mem_ce_n), 32'(!busy_e));
    chk("oe_n", 32'(mem_if.mem_oe_n), 32'(!(m_kind == 1)));
    chk("we_n", 32'(mem_if.mem_we_n),
        32'(!(m_kind == 2 && m_age <= W + 1)));
    chk("mem_addr", 32'(mem_if.mem_addr), 32'(m_mar));
    chk("mem_wdata", 32'(mem_if.mem_wdata), 32'(m_mdr));
    chk("MAR_out", 32'(MAR_out), 32'(m_mar));
    chk("MDR_out", 32'(MDR_out), 32'(m_mdr));
`ifdef MDR_PARITY_EN
    chk("wpar", 32'(mem_if.mem_wpar), 32'(^m_mdr));
    chk("par_err", 32'(par_err),
        32'(done_e && m_kind == 1 &&
            ((^mem_img[m_mar[7:0]]) ^ rpar)));
`endif
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic clr();
    LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
    start_rd = 1'b0; start_wr = 1'b0;
  endtask

  task automatic idle(int n);
    clr();
    for (int i = 0; i < n; i++) cycle();
  endtask

  // start already driven; returns cycles from start until done
  task automatic wait_done(output int lat);
    cycle();
    lat = 1;
    while (!done && lat < 12) begin
      clr();
      cycle();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int we_lo;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    mem_img[8'h40] = 16'h1234;
    mem_img[8'h01] = 16'h0001;

    Reset = 1'b0;
    cycle();
    cycle();
    Reset = 1'b1;
    idle(2);

    bus = 16'h3000; LD_MAR = 1'b1;
    cycle();
    clr(); bus = 16'hABCD; LD_MDR = 1'b1;
    cycle();
    clr(); start_wr = 1'b1;
    cycle();
    lat = 1;
    we_lo = mem_if.mem_we_n ? 0 : 1;
    chk("wr_addr", 32'(mem_if.mem_addr), 32'h3000);
    chk("wr_data", 32'(mem_if.mem_wdata), 32'hABCD);
    while (!done && lat < 12) begin
      clr();
      cycle();
      lat++;
      if (!mem_if.mem_we_n) we_lo++;
    end
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_we_cycles", 32'(we_lo), 32'd2);
    idle(2);

    bus = 16'h0040; LD_MAR = 1'b1;
    cycle();
    clr(); start_rd = 1'b1;
    wait_done(lat);
    chk("rd_lat", 32'(lat), 32'd3);
    idle(1);
    chk("rd_data", 32'(MDR_out), 32'h1234);

    start_rd = 1'b1; start_wr = 1'b1;
    cycle();
    chk("dual_err", 32'(err), 32'd1);
    idle(2);

    start_rd = 1'b1;
    cycle();
    clr(); bus = 16'hFFFF; LD_MDR = 1'b1;
    cycle();
    chk("ld_ignored", 32'(MDR_out), 32'h1234);
    idle(4);

    start_wr = 1'b1;
    cycle();
    clr();
    cycle();
    Reset = 1'b0;
    cycle();
    Reset = 1'b1;
    idle(4);

`ifdef MDR_PARITY_EN
    bus = 16'h0001; LD_MAR = 1'b1; rpar = 1'b0;
    cycle();
    clr(); start_rd = 1'b1;
    wait_done(lat);
    chk("par_bad", 32'(par_err), 32'd1);
    idle(2);
    rpar = 1'b1; start_rd = 1'b1;
    wait_done(lat);
    chk("par_ok", 32'(par_err), 32'd0);
    idle(2);
`endif

    for (int i = 0; i < 600; i++) begin
      Reset    = ($urandom_range(0, 59) != 0);
      bus      = 16'($urandom);
      LD_MAR   = ($urandom_range(0, 3) == 0);
      LD_MDR   = ($urandom_range(0, 3) == 0);
      MIO_EN   = 1'($urandom);
      start_rd = ($urandom_range(0, 5) == 0);
      start_wr = ($urandom_range(0, 5) == 0);
`ifdef MDR_PARITY_EN
      if (m_kind == 0) rpar = 1'($urandom);
`endif
      cycle();
    end
    Reset = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
- Parametrised memory data/address port for the LC-3-style datapath; successor to the fixed 16-bit MDR with its two-input mux.
- Holds MAR and MDR and drives an SRAM-style memory interface (active-low CE/OE/WE).
- Sequences read and write cycles with a configurable wait-state count, and reports busy/done to the control FSM.
- Sits between the CPU bus and the memory subsystem.

Parameters:
- DATA_W, 16, width of MDR, bus and memory data.
- ADDR_W, 16, width of MAR and mem_addr.
- WAIT_CYCLES, 1, cycles the memory needs between strobe assertion and valid data or write commit; range 0..15.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset; Reset=0 at a rising edge resets all state.
- bus  in  DATA_W  CPU bus value.
- LD_MAR  in  1  load MAR from bus[ADDR_W-1:0].
- LD_MDR  in  1  load MDR from the mux selected by MIO_EN.
- MIO_EN  in  1  MDR mux select: 1 = mem_rdata, 0 = bus.
- start_rd  in  1  begin a memory read at MAR.
- start_wr  in  1  begin a memory write of MDR to MAR.
- mem_rdata  in  DATA_W  memory read data.
- mem_addr  out  ADDR_W  equals MAR.
- mem_wdata  out  DATA_W  equals MDR.
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low memory strobes.
- MAR_out  out  ADDR_W  MAR contents.
- MDR_out  out  DATA_W  MDR contents.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse when a request is illegal.

Behaviour:
- Reset values:
  - MAR=0, MDR=0, state=IDLE, wait counter=0.
  - mem_ce_n=mem_oe_n=mem_we_n=1.
  - busy=0, done=0, err=0.
- FSM states: IDLE, RD_WAIT, RD_CAP, WR_WAIT, WR_END.
- IDLE:
  - LD_MAR and LD_MDR act with 1-cycle latency; the two may be asserted together.
  - start_rd alone -> RD_WAIT, counter=WAIT_CYCLES.
  - start_wr alone -> WR_WAIT, counter=WAIT_CYCLES.
  - start_rd and start_wr together -> stay IDLE, err=1 for one cycle, no strobes.
  - If LD_MAR or LD_MDR coincides with a start, the register loads first and the transaction uses the new value on the next cycle.
- RD_WAIT:
  - ce_n=0, oe_n=0.
  - Counter decrements each cycle; at 0 -> RD_CAP.
- RD_CAP:
  - ce_n=0, oe_n=0; MDR<=mem_rdata; done=1 -> IDLE.
  - Total read latency from start_rd to done = WAIT_CYCLES+2 cycles.
- WR_WAIT:
  - ce_n=0, we_n=0.
  - Counter decrements; at 0 -> WR_END.
- WR_END:
  - ce_n=0, we_n=1 (data hold cycle); done=1 -> IDLE.
- Signals in any state other than IDLE:
  - busy=1.
  - LD_MAR and LD_MDR are ignored, so MAR/MDR stay stable while the memory is accessed.
  - start_rd/start_wr -> err pulse; the current transaction continues unaffected.
- Strobe rules:
  - oe_n and we_n are never both 0.
  - Strobes are registered outputs, glitch-free.
- Reset=0 mid-transaction: on the next edge, strobes deassert and the FSM returns to IDLE; no done pulse is issued.
- WAIT_CYCLES=0: RD_WAIT and WR_WAIT last 1 cycle each.
- Counter width is 4 bits. A parameter value above 15 is an elaboration error (assertion).

Optional Feature:
- Macro: MDR_PARITY_EN.
- Defined:
  - Extra ports mem_rpar (in, 1) and par_err (out, 1).
  - MDR gains a parity bit.
  - In RD_CAP, if the XOR of mem_rdata and mem_rpar is not even, par_err pulses together with done. MDR is still loaded.
  - During a write, mem_wpar (out, 1) = even parity of MDR.
- Undefined: no parity ports or logic; behaviour otherwise identical.

Decomposition:
- Package mdr_pkg:
  - state enum mdr_state_t {IDLE, RD_WAIT, RD_CAP, WR_WAIT, WR_END}.
  - localparam WAIT_CNT_W=4.
  - Default width constants.
- One sub-module, reg_n: parametrised-width load register with synchronous active-low reset. Used for MAR and MDR (MDR instance widened by 1 when parity is enabled).

Test Plan:
- Reset=0 for 2 cycles, then release -> all outputs at reset values; all strobes 1.
- bus=16'h3000 with LD_MAR; then bus=16'hABCD with LD_MDR, MIO_EN=0; then start_wr with WAIT_CYCLES=1 -> we_n=0 for 2 cycles with mem_addr=16'h3000 and mem_wdata=16'hABCD; done pulses 3 cycles after start_wr; busy high throughout.
- MAR=16'h0040; start_rd; memory model returns 16'h1234 -> MDR_out=16'h1234 after done; done arrives exactly 3 cycles after start_rd; oe_n low for those cycles.
- start_rd and start_wr asserted together in IDLE -> err pulses once, no strobe activity, busy stays 0. Separately, LD_MDR during RD_WAIT -> MDR unchanged.
- Reset=0 on the second cycle of WR_WAIT -> strobes deassert on the next edge, FSM returns to IDLE, no done pulse.
- With MDR_PARITY_EN: mem_rdata=16'h0001, mem_rpar=0 -> par_err pulses together with done; mem_rpar=1 -> no par_err.
